// File: rtl/alu_defs_pkg.sv
// Function codes shared by the ALU datapath units, plus the divider state encoding.
package alu_defs_pkg;
    localparam logic [5:0] AND_CODE  = 6'b100100;
    localparam logic [5:0] OR_CODE   = 6'b100101;
    localparam logic [5:0] ADD_CODE  = 6'b100000;
    localparam logic [5:0] SUB_CODE  = 6'b100010;
    localparam logic [5:0] SLT_CODE  = 6'b101010;
    localparam logic [5:0] SRL_CODE  = 6'b000010;
    localparam logic [5:0] MUT_CODE  = 6'b011000;
    localparam logic [5:0] MFHI_CODE = 6'b010000;
    localparam logic [5:0] MFLO_CODE = 6'b010010;
    localparam logic [5:0] DIVU_CODE = 6'b011011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } divu_state_t;
endpackage

// File: rtl/divu_unit_if.sv
// Operand/handshake/result bundle between the ALU datapath and the divider.
interface divu_unit_if #(parameter int WIDTH = 32);
    logic [WIDTH-1:0]   dataA;
    logic [WIDTH-1:0]   dataB;
    logic [5:0]         Signal;
    logic               start;
    logic               busy;
    logic               done;
    logic               div_zero;
    logic [2*WIDTH-1:0] divAns;

    modport master (output dataA, dataB, Signal, start,
                    input  busy, done, div_zero, divAns);
    modport slave  (input  dataA, dataB, Signal, start,
                    output busy, done, div_zero, divAns);
endinterface

// File: rtl/divu_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract the divisor, select.
module divu_step #(parameter int WIDTH = 32) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dvsr,
    output logic [WIDTH-1:0] rem_n,
    output logic [WIDTH-1:0] quo_n
);
    logic [WIDTH:0] rem_sh;
    logic           ge;

    assign rem_sh = {rem, quo[WIDTH-1]};
    assign ge     = rem_sh >= {1'b0, dvsr};
    // When ge holds the difference is below dvsr, so WIDTH-bit arithmetic is exact.
    assign rem_n  = ge ? (rem_sh[WIDTH-1:0] - dvsr) : rem_sh[WIDTH-1:0];
    assign quo_n  = {quo[WIDTH-2:0], ge};
endmodule

// File: rtl/divu_unit.sv
// Sequential radix-2 restoring unsigned divider; result {remainder, quotient} for HiLo.
module divu_unit
    import alu_defs_pkg::*;
#(
    parameter int         WIDTH     = 32,
    parameter logic [5:0] DIVU_SIG  = DIVU_CODE
) (
    input  logic        clk,
    input  logic        reset,
    divu_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    divu_state_t        state, state_n;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   rem, quo, dvsr;
    logic [WIDTH-1:0]   rem_n, quo_n;
    logic [2*WIDTH-1:0] ans;
    logic               dz;
    logic               accept, last;

    assign accept = (state == IDLE) && bus.start && (bus.Signal == DIVU_SIG);
    assign last   = (count == CW'(WIDTH-1));

    divu_step #(.WIDTH(WIDTH)) u_step (
        .rem   (rem),
        .quo   (quo),
        .dvsr  (dvsr),
        .rem_n (rem_n),
        .quo_n (quo_n)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = BUSY;
            BUSY:    if (last)   state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            rem   <= '0;
            quo   <= '0;
            dvsr  <= '0;
            ans   <= '0;
            dz    <= 1'b0;
        end else if (accept) begin
            count <= '0;
            rem   <= '0;
            quo   <= bus.dataA;
            dvsr  <= bus.dataB;
            dz    <= (bus.dataB == '0);
        end else if (state == BUSY) begin
            rem   <= rem_n;
            quo   <= quo_n;
            count <= count + 1'b1;
            if (last) ans <= {rem_n, quo_n};
        end
    end

    assign bus.busy     = (state == BUSY) || (state == DONE);
    assign bus.done     = (state == DONE);
    assign bus.div_zero = dz;
    assign bus.divAns   = ans;
endmodule
